uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter p_num_req, default 4, number of requesters (legal 2..8).
REQ-002 Parameter p_ack_timeout, default 65535, i_clk cycles allowed for the transmitter to acknowledge start (legal 16..65535).
REQ-003 Port i_clk  input  1  system clock; the only clock.
REQ-004 Port i_rst  input  1  synchronous, active-high reset.
REQ-005 Port i_req_valid  input  p_num_req  per-requester byte-available flag; bit n belongs to requester n.
REQ-006 Port i_req_data  input  8*p_num_req  per-requester byte; requester n on bits [8n+7:8n].
REQ-007 Port o_req_ready  output  p_num_req  one-cycle accept pulse; at most one bit set.
REQ-008 Port o_tx_start  output  1  start level to the shared UART transmitter.
REQ-009 Port o_tx_data  output  8  byte to the shared UART transmitter.
REQ-010 Port i_tx_done  input  1  transmitter idle flag, baud-clock domain; high = idle.
REQ-011 Port o_grant_id  output  3  index of the requester owning the current or last transfer.
REQ-012 Port o_busy  output  1  high while any state other than IDLE is active.
REQ-013 Port o_err  output  1  one-cycle pulse on acknowledge timeout.

Function
REQ-014 i_tx_done passes through a 2-flop synchronizer; all uses below refer to the synchronized value (done_s).
REQ-015 States: IDLE, ARB, START, WAIT_DONE.
REQ-016 IDLE: if any i_req_valid bit is set and done_s=1, go to ARB next cycle; otherwise stay.
REQ-017 ARB, winner selection: round-robin; winner = first set valid bit searching upward (with wrap) from ptr, where ptr = (last winner + 1) mod p_num_req.
REQ-018 ARB, capture: o_req_ready[winner]=1 for exactly this cycle; latch i_req_data byte into o_tx_data; set o_grant_id=winner; update ptr; go to START.
REQ-019 ARB with no valid bit set (valid withdrawn) returns to IDLE with no ready pulse, ptr unchanged.
REQ-020 START: o_tx_start=1; stay until done_s=0, then go to WAIT_DONE.
REQ-021 START timeout counter counts i_clk cycles spent in START; at count p_ack_timeout-1 without done_s=0: o_tx_start=0, o_err pulse, go to IDLE; the byte is dropped and ptr stays advanced.
REQ-022 WAIT_DONE: o_tx_start=0; stay until done_s=1, then go to IDLE.
REQ-023 o_tx_start holding high until acknowledged guarantees the transmitter's baud-rate edge detector sees a rising edge; o_tx_start is low for at least 1 cycle between transfers (IDLE and ARB).
REQ-024 o_tx_data stays stable from ARB exit until the next ARB capture.
REQ-025 i_req_valid/i_req_data changes outside the ARB cycle have no effect on an in-flight transfer.
REQ-026 A requester holding valid continuously gets one byte per ready pulse; with all requesters valid, grants rotate 0,1,...,p_num_req-1,0.
REQ-027 Minimum latency valid->ready is 2 cycles (IDLE sample, ARB).

Reset
REQ-028 While i_rst=1 at a clock edge, all state resets: state=IDLE, ptr=0, o_grant_id=0, o_tx_data=0, o_tx_start=0, o_req_ready=0, o_busy=0, o_err=0, timeout counter=0, synchronizer flops=1.
REQ-029 Reset mid-transfer drops o_tx_start on the next edge; the partially sent byte is not retried.
REQ-030 First arbitration after reset starts search at requester 0.

Verification
REQ-031 Single request: i_req_valid=4'b0100, data 0xA5, transmitter model acks after 20 cycles -> o_req_ready=4'b0100 pulse, o_tx_data=0xA5, o_grant_id=2, o_tx_start high until ack, o_busy drops after done returns.
REQ-032 All four valid continuously with bytes 0x10..0x13 -> 8 transfers in order 0,1,2,3,0,1,2,3, each data value matching its requester.
REQ-033 i_tx_done held high forever, p_ack_timeout=16 -> o_tx_start high 16 cycles, o_err single pulse, return to IDLE, next grant goes to next requester.
REQ-034 i_rst pulse while in WAIT_DONE -> next cycle all outputs at reset values; subsequent request from requester 3 with ptr=0 is granted normally.
REQ-035 Valid asserted while i_tx_done low (transmitter busy) -> no ready pulse until done_s=1, then grant within 2 cycles.
REQ-036 Valid withdrawn in the same cycle the FSM enters ARB -> no ready pulse, no o_tx_start, return to IDLE.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among several byte requesters.
// Holds the transmitter start level until the transmitter acknowledges, with an acknowledge timeout.
module uart_tx_arbiter #(
  parameter int unsigned p_num_req     = 4,
  parameter int unsigned p_ack_timeout = 65535
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [p_num_req-1:0]   i_req_valid,
  input  logic [8*p_num_req-1:0] i_req_data,
  output logic [p_num_req-1:0]   o_req_ready,
  output logic                   o_tx_start,
  output logic [7:0]             o_tx_data,
  input  logic                   i_tx_done,
  output logic [2:0]             o_grant_id,
  output logic                   o_busy,
  output logic                   o_err
);

  localparam int unsigned c_idx_w = (p_num_req > 1) ? $clog2(p_num_req) : 1;

  typedef enum logic [1:0] {IDLE, ARB, START, WAIT_DONE} state_t;

  state_t               state, state_nxt;
  logic                 done_meta, done_s;
  logic [2:0]           ptr, ptr_nxt, win;
  logic                 win_vld;
  logic [p_num_req-1:0] win_oh;
  logic [7:0]           win_data;
  logic [15:0]          to_cnt;
  logic                 ack_expired;

  // Search upward from ptr with wrap; first valid requester wins.
  always_comb begin
    logic [3:0] idx;
    idx     = '0;
    win     = '0;
    win_vld = 1'b0;
    for (int unsigned i = 0; i < p_num_req; i++) begin
      idx = 4'(ptr) + 4'(i);
      if (idx >= 4'(p_num_req)) idx = idx - 4'(p_num_req);
      if (!win_vld && i_req_valid[idx[c_idx_w-1:0]]) begin
        win_vld = 1'b1;
        win     = 3'(idx);
      end
    end
  end

  always_comb begin
    win_oh   = '0;
    win_data = '0;
    for (int unsigned i = 0; i < p_num_req; i++) begin
      if (3'(i) == win) begin
        win_oh[i] = 1'b1;
        win_data  = i_req_data[8*i +: 8];
      end
    end
  end

  assign ptr_nxt     = (win == 3'(p_num_req - 1)) ? '0 : win + 3'd1;
  assign ack_expired = (to_cnt == 16'(p_ack_timeout - 1));
  assign o_busy      = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    o_req_ready = '0;
    o_tx_start  = 1'b0;
    o_err       = 1'b0;
    case (state)
      IDLE: if ((|i_req_valid) && done_s) state_nxt = ARB;
      ARB: begin
        if (win_vld) begin
          o_req_ready = win_oh;
          state_nxt   = START;
        end else begin
          state_nxt = IDLE;
        end
      end
      START: begin
        o_tx_start = 1'b1;
        if (!done_s) begin
          state_nxt = WAIT_DONE;
        end else if (ack_expired) begin
          o_err     = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT_DONE: if (done_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      done_meta  <= 1'b1;
      done_s     <= 1'b1;
      ptr        <= '0;
      o_grant_id <= '0;
      o_tx_data  <= '0;
      to_cnt     <= '0;
    end else begin
      done_meta <= i_tx_done;
      done_s    <= done_meta;
      state     <= state_nxt;
      if (state == ARB && win_vld) begin
        o_tx_data  <= win_data;
        o_grant_id <= win;
        ptr        <= ptr_nxt;
      end
      // Counts cycles already spent in START; zero on entry.
      if (state == START && state_nxt == START) to_cnt <= to_cnt + 16'd1;
      else                                      to_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table plus hand sequences,
// with a ready-pulse scoreboard and a simple transmitter model.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data  = '0;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic [2:0]  grant_id;
  logic        busy, err;

  logic [3:0]  valid2 = '0;
  logic [31:0] data2  = '0;
  logic [3:0]  ready2;
  logic        start2, busy2, err2;
  logic [7:0]  txd2;
  logic [2:0]  grant2;
  logic        done2 = 1'b1;

  logic tx_auto = 1'b1;
  logic done_man = 1'b1;
  logic done_auto = 1'b1;
  int   ack_delay = 5;
  int   busy_len = 12;
  int   ack_cnt = 0;
  int   busy_cnt = 0;

  int checks = 0;
  int errors = 0;
  int ready_pulses = 0;

  typedef struct { logic [2:0] id; logic [7:0] data; } exp_t;
  exp_t sb[$];

  typedef struct { logic [3:0] valid; logic [7:0] dbase; logic [2:0] exp_id; } vec_t;
  vec_t tbl[8];

  assign tx_done = tx_auto ? done_auto : done_man;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.p_num_req(4), .p_ack_timeout(65535)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
    .o_req_ready(req_ready), .o_tx_start(tx_start), .o_tx_data(tx_data),
    .i_tx_done(tx_done), .o_grant_id(grant_id), .o_busy(busy), .o_err(err));

  uart_tx_arbiter #(.p_num_req(4), .p_ack_timeout(16)) dut_to (
    .i_clk(clk), .i_rst(rst), .i_req_valid(valid2), .i_req_data(data2),
    .o_req_ready(ready2), .o_tx_start(start2), .o_tx_data(txd2),
    .i_tx_done(done2), .o_grant_id(grant2), .o_busy(busy2), .o_err(err2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transmitter: acks ack_delay cycles after start is seen, then stays busy busy_len cycles.
  always begin
    @(posedge clk);
    #1;
    if (tx_auto) begin
      if (done_auto) begin
        if (tx_start) begin
          ack_cnt++;
          if (ack_cnt >= ack_delay) begin
            done_auto = 1'b0;
            ack_cnt   = 0;
            busy_cnt  = busy_len;
          end
        end else begin
          ack_cnt = 0;
        end
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end else begin
        done_auto = 1'b1;
      end
    end
  end

  logic [3:0] mon_ready;
  bit         mon_pend = 0;
  always @(negedge clk) begin
    exp_t e;
    if (mon_pend) begin
      mon_pend = 0;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got ready 0x%0h expected no pulse", mon_ready);
      end else begin
        e = sb.pop_front();
        chk("ready_vector", 32'(mon_ready), 32'(4'b0001 << e.id));
        chk("grant_id", 32'(grant_id), 32'(e.id));
        chk("tx_data", 32'(tx_data), 32'(e.data));
      end
    end
    if (req_ready != '0) begin
      mon_pend  = 1;
      mon_ready = req_ready;
      ready_pulses++;
      chk("ready_onehot", 32'($countones(req_ready)), 32'd1);
    end
  end

  task automatic drive(input logic [3:0] v, input logic [7:0] base);
    @(posedge clk);
    #1;
    for (int n = 0; n < 4; n++) req_data[8*n +: 8] = base + 8'(n);
    req_valid = v;
  endtask

  task automatic drop_valid();
    @(posedge clk);
    #1;
    req_valid = '0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == '0 && n < 300);
    if (req_ready == '0) chk("wait_ready_timeout", 32'(n), 32'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(busy == 1'b0 && tx_done == 1'b1) && n < 500);
    if (busy) chk("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_done_level(input logic lvl);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx_done != lvl && n < 200);
    if (tx_done != lvl) chk("wait_tx_done_timeout", 32'(tx_done), 32'(lvl));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic push(input logic [2:0] id, input logic [7:0] data);
    exp_t e;
    e.id = id;
    e.data = data;
    sb.push_back(e);
  endtask

  initial begin
    int n, p0, scnt, ecnt;
    tbl[0] = '{4'b1111, 8'h20, 3'd3};
    tbl[1] = '{4'b0011, 8'h30, 3'd0};
    tbl[2] = '{4'b0001, 8'h40, 3'd0};
    tbl[3] = '{4'b1001, 8'h50, 3'd3};
    tbl[4] = '{4'b0110, 8'h60, 3'd1};
    tbl[5] = '{4'b0011, 8'h70, 3'd0};
    tbl[6] = '{4'b1000, 8'h80, 3'd3};
    tbl[7] = '{4'b1100, 8'h90, 3'd2};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_start", 32'(tx_start), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Single request from requester 2, slow acknowledge.
    ack_delay = 20;
    push(3'd2, 8'hA5);
    drive(4'b0100, 8'hA3);
    wait_ready(n);
    chk("single_latency", 32'(n), 32'd2);
    drop_valid();
    @(negedge clk);
    chk("single_start_high", 32'(tx_start), 32'd1);
    wait_done_level(1'b0);
    repeat (3) @(negedge clk);
    chk("wait_done_start_low", 32'(tx_start), 32'd0);
    chk("wait_done_busy", 32'(busy), 32'd1);
    wait_done_level(1'b1);
    repeat (3) @(negedge clk);
    chk("single_busy_drop", 32'(busy), 32'd0);
    ack_delay = 5;

    for (int i = 0; i < 8; i++) begin
      wait_idle();
      push(tbl[i].exp_id, tbl[i].dbase + 8'(tbl[i].exp_id));
      drive(tbl[i].valid, tbl[i].dbase);
      wait_ready(n);
      drop_valid();
    end

    // Valid withdrawn as ARB is entered: no pulse, pointer untouched.
    wait_idle();
    p0 = ready_pulses;
    drive(4'b0010, 8'hB0);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    chk("withdraw_in_arb", 32'(busy), 32'd1);
    chk("withdraw_no_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("withdraw_idle", 32'(busy), 32'd0);
    chk("withdraw_no_start", 32'(tx_start), 32'd0);
    chk("withdraw_pulses", 32'(ready_pulses - p0), 32'd0);
    push(3'd3, 8'hC3);
    drive(4'b1111, 8'hC0);
    wait_ready(n);
    drop_valid();

    // Request while transmitter busy.
    wait_idle();
    @(posedge clk);
    #1 done_man = 1'b0;
    tx_auto = 1'b0;
    repeat (3) @(posedge clk);
    p0 = ready_pulses;
    push(3'd0, 8'hD0);
    drive(4'b0001, 8'hD0);
    repeat (8) @(negedge clk);
    chk("busy_tx_no_ready", 32'(ready_pulses - p0), 32'd0);
    @(posedge clk);
    #1 done_man = 1'b1;
    wait_ready(n);
    chk("busy_tx_grant_latency", 32'(n <= 4), 32'd1);
    @(posedge clk);
    #1 req_valid = '0;
    tx_auto = 1'b1;

    // Reset during WAIT_DONE.
    wait_idle();
    push(3'd2, 8'hE2);
    drive(4'b0100, 8'hE0);
    wait_ready(n);
    drop_valid();
    wait_done_level(1'b0);
    repeat (3) @(negedge clk);
    chk("pre_reset_wait_done", 32'(busy), 32'd1);
    do_reset();
    @(negedge clk);
    chk("mid_rst_start", 32'(tx_start), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_grant", 32'(grant_id), 32'd0);
    chk("mid_rst_data", 32'(tx_data), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    wait_idle();
    push(3'd1, 8'hF1);
    drive(4'b1010, 8'hF0);
    wait_ready(n);
    drop_valid();
    wait_idle();
    push(3'd3, 8'h13);
    drive(4'b1000, 8'h10);
    wait_ready(n);
    drop_valid();

    // All requesters valid continuously from a fresh pointer.
    wait_idle();
    do_reset();
    for (int k = 0; k < 8; k++) push(3'(k % 4), 8'h10 + 8'(k % 4));
    drive(4'b1111, 8'h10);
    for (int k = 0; k < 8; k++) begin
      wait_ready(n);
      if (k < 7) @(posedge clk);
    end
    drop_valid();
    wait_idle();

    // Acknowledge timeout on the short-timeout instance.
    @(posedge clk);
    #1 data2 = 32'h44332211;
    valid2 = 4'b1111;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ready2 == '0 && n < 50);
    chk("to_first_ready", 32'(ready2), 32'b0001);
    scnt = 0;
    ecnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (k == 0) chk("to_first_grant", 32'(grant2), 32'd0);
      if (start2) scnt++;
      if (err2) ecnt++;
      if (!busy2) break;
    end
    chk("to_start_cycles", 32'(scnt), 32'd16);
    chk("to_err_pulses", 32'(ecnt), 32'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ready2 == '0 && n < 50);
    chk("to_next_ready", 32'(ready2), 32'b0010);
    @(negedge clk);
    chk("to_next_grant", 32'(grant2), 32'd1);
    chk("to_next_data", 32'(txd2), 32'h22);
    @(posedge clk);
    #1 valid2 = '0;

    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
